// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and
// cmov/jXX condition evaluation feeding decode forwarding and the memory stage.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E_bubble,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_stat,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_stat,
  output logic [63:0] E_valA,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [2:0]  cc
);

  localparam int unsigned XW = 64;
  localparam int unsigned NW = 4;
  localparam logic [NW-1:0] REG_NONE = 4'hF;
  localparam logic [NW-1:0] I_NOP    = 4'h1;
  localparam logic [NW-1:0] I_OPQ    = 4'h6;
  localparam logic [NW-1:0] I_RRMOVQ = 4'h2;
  localparam logic [NW-1:0] S_AOK    = 4'h1;
  localparam logic [XW-1:0] MINUS_8  = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [XW-1:0] PLUS_8   = 64'h0000_0000_0000_0008;

  logic [NW-1:0] icode_q, icode_d, ifun_q, ifun_d, stat_q, stat_d;
  logic [XW-1:0] valc_q, valc_d, vala_q, vala_d, valb_q, valb_d;
  logic [NW-1:0] dste_q, dste_d, dstm_q, dstm_d, srca_q, srca_d, srcb_q, srcb_d;
  logic [2:0]    cc_q, cc_d;

  logic [XW-1:0] alu_a, alu_b, alu_res;
  logic [NW-1:0] alu_fun;
  logic          zf_n, sf_n, of_n, set_cc, cnd;
  logic          zf, sf, of_f;

  // E register next value: bubble overrides the decode fields
  always_comb begin
    icode_d = d_icode;
    ifun_d  = d_ifun;
    stat_d  = d_stat;
    valc_d  = d_valC;
    vala_d  = d_valA;
    valb_d  = d_valB;
    dste_d  = d_dstE;
    dstm_d  = d_dstM;
    srca_d  = d_srcA;
    srcb_d  = d_srcB;
    if (E_bubble) begin
      icode_d = I_NOP;
      ifun_d  = '0;
      stat_d  = S_AOK;
      valc_d  = '0;
      vala_d  = '0;
      valb_d  = '0;
      dste_d  = REG_NONE;
      dstm_d  = REG_NONE;
      srca_d  = REG_NONE;
      srcb_d  = REG_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q <= I_NOP;
      ifun_q  <= '0;
      stat_q  <= S_AOK;
      valc_q  <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      dste_q  <= REG_NONE;
      dstm_q  <= REG_NONE;
      srca_q  <= REG_NONE;
      srcb_q  <= REG_NONE;
      cc_q    <= 3'b100;
    end else begin
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      stat_q  <= stat_d;
      valc_q  <= valc_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      cc_q    <= cc_d;
    end
  end

  // ALU operand selection
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode_q)
      4'h2, 4'h6:       alu_a = vala_q;
      4'h3, 4'h4, 4'h5: alu_a = valc_q;
      4'h8, 4'hA:       alu_a = MINUS_8;
      4'h9, 4'hB:       alu_a = PLUS_8;
      default:          alu_a = '0;
    endcase
    case (icode_q)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = valb_q;
      default:                                  alu_b = '0;
    endcase
  end

  // ALU and flag generation; undefined OPq functions yield zero
  always_comb begin
    alu_fun = (icode_q == I_OPQ) ? ifun_q : 4'h0;
    alu_res = '0;
    of_n    = 1'b0;
    case (alu_fun)
      4'h0: begin
        alu_res = alu_b + alu_a;
        of_n    = (alu_a[XW-1] == alu_b[XW-1]) && (alu_res[XW-1] != alu_a[XW-1]);
      end
      4'h1: begin
        alu_res = alu_b - alu_a;
        of_n    = (alu_a[XW-1] != alu_b[XW-1]) && (alu_res[XW-1] != alu_b[XW-1]);
      end
      4'h2:    alu_res = alu_a & alu_b;
      4'h3:    alu_res = alu_a ^ alu_b;
      default: alu_res = '0;
    endcase
    zf_n = (alu_res == '0);
    sf_n = alu_res[XW-1];
  end

  // CC update is blocked when an older instruction has faulted or halted
  always_comb begin
    set_cc = (icode_q == I_OPQ) && (ifun_q <= 4'h3)
          && !(m_stat inside {4'h2, 4'h3, 4'h4})
          && !(W_stat inside {4'h2, 4'h3, 4'h4});
    cc_d = set_cc ? {zf_n, sf_n, of_n} : cc_q;
  end

  always_comb begin
    {zf, sf, of_f} = cc_q;
    case (ifun_q)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of_f) | zf;
      4'h2:    cnd = sf ^ of_f;
      4'h3:    cnd = zf;
      4'h4:    cnd = ~zf;
      4'h5:    cnd = ~(sf ^ of_f);
      4'h6:    cnd = ~(sf ^ of_f) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign E_icode = icode_q;
  assign E_ifun  = ifun_q;
  assign E_stat  = stat_q;
  assign E_valA  = vala_q;
  assign E_dstM  = dstm_q;
  assign E_srcA  = srca_q;
  assign E_srcB  = srcb_q;
  assign cc      = cc_q;
  assign e_valE  = alu_res;
  assign e_Cnd   = cnd;
  assign e_dstE  = ((icode_q == I_RRMOVQ) && !cnd) ? REG_NONE : dste_q;

endmodule
